display_scheduler: RTL and testbench
====================================

DISPLAY_SCHEDULER -- requirements
Module: display_scheduler

Interface
REQ-001 Parameter DIV, default 50000: clk cycles per digit-scan tick; legal range 2..65535.
REQ-002 Parameter HOLD_FRAMES, default 2: minimum number of scan-frame pulses a loaded value stays displayed; legal range 1..15.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 req  in  3  level request per source; bit i set means source i wants the display.
REQ-006 data0, data1, data2  in  16 each  four-digit nibble value offered by source 0/1/2.
REQ-007 q  out  16  registered value driven to the seven-segment driver.
REQ-008 clk_div  out  1  one-cycle scan-tick pulse for the seven-segment driver.
REQ-009 frame  out  1  one-cycle pulse on every 4th clk_div pulse, marking a full four-digit scan.
REQ-010 ack  out  3  one-hot, one-cycle pulse to the source whose data was loaded into q.
REQ-011 owner  out  2  index of the source last loaded; 2'd3 means none since reset.

Function
REQ-012 Prescaler: counter runs 0..DIV-1 and wraps; clk_div is 1 exactly in the cycle the counter equals DIV-1.
REQ-013 Frame counter: 2-bit counter increments on each clk_div pulse and wraps 3->0; frame is 1 exactly when clk_div=1 and the frame counter equals 3.
REQ-014 Prescaler and frame counter run freely, independent of FSM state and requests.
REQ-015 The FSM has two states: IDLE (no hold active) and SHOW (hold active).
REQ-016 Load event: at a clock edge, q <= data of the winner; ack one-hot for the winner for the next cycle only; owner <= winner; hold counter <= 0; state <= SHOW.
REQ-017 In IDLE, a load event occurs at every edge where req != 0, giving a one-cycle latency from sampled req to q and ack.
REQ-018 In IDLE with req == 0, q, owner and ack=0 hold their values.
REQ-019 Round-robin order: priority starts at (owner+1) mod 3; when owner=3, the order is 0,1,2.
REQ-020 Only requesting sources are eligible; the first eligible source in priority order wins.
REQ-021 In SHOW, the hold counter increments on each frame pulse.
REQ-022 At the edge where a frame pulse brings the hold count to HOLD_FRAMES: if req != 0, a load event occurs (state stays SHOW); otherwise state <= IDLE.
REQ-023 Requests arriving or dropping during SHOW have no effect until the hold expires; no ack is issued in SHOW except at expiry.
REQ-024 A source that holds req after its ack competes again, with lowest priority (round-robin fairness).
REQ-025 Only the sole requester keeps the display: it is re-acked at each hold expiry.
REQ-026 ack has at most one bit set in any cycle; q changes only on load events.
REQ-027 data inputs are sampled only at the load edge; later changes do not alter q.

Reset
REQ-028 While rst=0, asynchronously: q=16'h0000, clk_div=0, frame=0, ack=3'b000, owner=2'd3, state=IDLE, prescaler=0, frame counter=0, hold counter=0.
REQ-029 Reset asserted mid-SHOW aborts the hold immediately; no ack is issued for a pending request.
REQ-030 After rst deasserts, the first clk_div pulse occurs DIV cycles later.
REQ-031 After rst deasserts, the first load event may occur at the first clock edge.

Verification (DIV=4, HOLD_FRAMES=2)
REQ-032 Release reset with no requests -> clk_div pulses every 4 cycles, frame every 16 cycles, q=0000, owner=3, ack=000 throughout.
REQ-033 From IDLE, req=001 with data0=16'h1234 -> next cycle q=1234, ack=001 for one cycle, owner=0.
REQ-034 req=111 held, data0/1/2=AAAA/BBBB/CCCC -> q sequence AAAA, BBBB, CCCC, AAAA; each change aligned to the 2nd frame pulse after the previous load.
REQ-035 Owner 0 in SHOW, data0 changes and req=010 rises mid-hold -> q unchanged until expiry, then q=data1 and ack=010.
REQ-036 Hold expires with req=000 -> state IDLE, q retained; a later req=100 loads with one-cycle latency, not frame-aligned.
REQ-037 rst=0 pulsed mid-SHOW with req=011 -> outputs reset at once; after release, source 0 wins first (owner=3 ordering).

Source files
------------

// File: rtl/display_scheduler.sv
// Round-robin arbiter that loads one of three four-digit sources into the
// seven-segment register and holds it for a minimum number of scan frames.
module display_scheduler #(
    parameter int DIV         = 50000,
    parameter int HOLD_FRAMES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    input  logic [15:0] data2,
    output logic [15:0] q,
    output logic        clk_div,
    output logic        frame,
    output logic [2:0]  ack,
    output logic [1:0]  owner
);

    localparam logic [0:0]  IDLE      = 1'b0;
    localparam logic [0:0]  SHOW      = 1'b1;
    localparam logic [15:0] PRESC_MAX = 16'(DIV - 1);
    localparam logic [3:0]  HOLD_MAX  = 4'(HOLD_FRAMES);

    logic [15:0] presc_q, presc_d;
    logic [1:0]  fcnt_q, fcnt_d;
    logic [3:0]  hold_q, hold_d;
    logic [0:0]  state_q, state_d;
    logic [15:0] q_q, q_d;
    logic [2:0]  ack_q, ack_d;
    logic [1:0]  owner_q, owner_d;
    logic        tick, frame_w, expire, load;
    logic [1:0]  winner;

    // Search starts just after the last owner; owner 3 (none yet) starts at 0.
    function automatic logic [1:0] pick_winner(input logic [2:0] r, input logic [1:0] own);
        logic [1:0] first;
        logic [1:0] idx;
        logic       found;
        first       = (own >= 2'd2) ? 2'd0 : own + 2'd1;
        pick_winner = 2'd0;
        found       = 1'b0;
        for (int k = 0; k < 3; k++) begin
            idx = 2'((int'(first) + k) % 3);
            if (!found && r[idx]) begin
                pick_winner = idx;
                found       = 1'b1;
            end
        end
    endfunction

    always_comb begin
        tick    = (presc_q == PRESC_MAX);
        frame_w = tick && (fcnt_q == 2'd3);
        presc_d = tick ? 16'd0 : presc_q + 16'd1;
        fcnt_d  = tick ? fcnt_q + 2'd1 : fcnt_q;
        winner  = pick_winner(req, owner_q);
        expire  = (state_q == SHOW) && frame_w && ((hold_q + 4'd1) == HOLD_MAX);
        load    = (req != 3'b000) && ((state_q == IDLE) || expire);

        state_d = state_q;
        hold_d  = hold_q;
        q_d     = q_q;
        owner_d = owner_q;
        ack_d   = 3'b000;

        if ((state_q == SHOW) && frame_w)
            hold_d = hold_q + 4'd1;
        if (expire && (req == 3'b000))
            state_d = IDLE;
        if (load) begin
            case (winner)
                2'd0:    q_d = data0;
                2'd1:    q_d = data1;
                default: q_d = data2;
            endcase
            ack_d   = 3'b001 << winner;
            owner_d = winner;
            hold_d  = 4'd0;
            state_d = SHOW;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q <= 16'd0;
            fcnt_q  <= 2'd0;
            hold_q  <= 4'd0;
            state_q <= IDLE;
            q_q     <= 16'h0000;
            ack_q   <= 3'b000;
            owner_q <= 2'd3;
        end else begin
            presc_q <= presc_d;
            fcnt_q  <= fcnt_d;
            hold_q  <= hold_d;
            state_q <= state_d;
            q_q     <= q_d;
            ack_q   <= ack_d;
            owner_q <= owner_d;
        end
    end

    assign q       = q_q;
    assign ack     = ack_q;
    assign owner   = owner_q;
    assign clk_div = tick;
    assign frame   = frame_w;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench for display_scheduler with DIV=4, HOLD_FRAMES=2:
// scan timing, round-robin order, frame-aligned hold expiry and reset abort.
module tb_display_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req;
    logic [15:0] data0, data1, data2;
    logic [15:0] q;
    logic        clk_div, frame;
    logic [2:0]  ack;
    logic [1:0]  owner;

    int nvec = 0;
    int nmis = 0;
    int cyc  = 0;

    display_scheduler #(.DIV(4), .HOLD_FRAMES(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .data0   (data0),
        .data1   (data1),
        .data2   (data2),
        .q       (q),
        .clk_div (clk_div),
        .frame   (frame),
        .ack     (ack),
        .owner   (owner)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    // One rising edge, then settle at the falling edge where outputs are sampled.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; req = 3'b000;
        data0 = 16'h0; data1 = 16'h0; data2 = 16'h0;
        @(posedge clk);
        @(negedge clk);
        check_vec("rst_q", q, 16'h0000);
        check_vec("rst_owner", owner, 2'd3);
        check_vec("rst_ack", ack, 3'b000);
        check_vec("rst_clk_div", clk_div, 1'b0);
        check_vec("rst_frame", frame, 1'b0);
        rst = 1'b1;
        cyc = 0;

        // Free-running scan: clk_div every 4 cycles, frame every 16.
        for (int i = 1; i <= 20; i++) begin
            step();
            check_vec("idle_clk_div", clk_div, (cyc % 4) == 3);
            check_vec("idle_frame", frame, (cyc % 16) == 15);
        end
        check_vec("idle_q", q, 16'h0000);
        check_vec("idle_owner", owner, 2'd3);
        check_vec("idle_ack", ack, 3'b000);

        // Single request from IDLE: one-cycle latency.
        data0 = 16'h1234; req = 3'b001;
        step();
        check_vec("ld0_q", q, 16'h1234);
        check_vec("ld0_ack", ack, 3'b001);
        check_vec("ld0_owner", owner, 2'd0);
        req = 3'b000;
        step();
        check_vec("ld0_ack_drop", ack, 3'b000);

        // Mid-hold request and data change are ignored until expiry at edge 48.
        data0 = 16'h5555; data1 = 16'hBEEF; req = 3'b010;
        run_to(47);
        check_vec("hold_q", q, 16'h1234);
        check_vec("hold_ack", ack, 3'b000);
        step();
        check_vec("exp_q", q, 16'hBEEF);
        check_vec("exp_ack", ack, 3'b010);
        check_vec("exp_owner", owner, 2'd1);
        req = 3'b000;
        step();
        check_vec("exp_ack_drop", ack, 3'b000);

        // Expiry with no request returns to IDLE; next load is not frame aligned.
        run_to(80);
        check_vec("toidle_q", q, 16'hBEEF);
        check_vec("toidle_owner", owner, 2'd1);
        check_vec("toidle_ack", ack, 3'b000);
        run_to(83);
        data2 = 16'hC0DE; req = 3'b100;
        step();
        check_vec("ld2_q", q, 16'hC0DE);
        check_vec("ld2_ack", ack, 3'b100);
        check_vec("ld2_owner", owner, 2'd2);
        req = 3'b000;

        // Reset mid-hold with a pending request.
        data0 = 16'hAAAA; data1 = 16'hBBBB; data2 = 16'hCCCC; req = 3'b011;
        run_to(99);
        check_vec("prerst_q", q, 16'hC0DE);
        check_vec("prerst_ack", ack, 3'b000);
        rst = 1'b0;
        #1;
        check_vec("arst_q", q, 16'h0000);
        check_vec("arst_owner", owner, 2'd3);
        check_vec("arst_ack", ack, 3'b000);
        check_vec("arst_clk_div", clk_div, 1'b0);
        check_vec("arst_frame", frame, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check_vec("inrst_ack", ack, 3'b000);
        rst = 1'b1;
        cyc = 0;
        step();
        check_vec("post_q", q, 16'hAAAA);
        check_vec("post_ack", ack, 3'b001);
        check_vec("post_owner", owner, 2'd0);
        req = 3'b111;
        step();
        check_vec("post_ack_drop", ack, 3'b000);
        check_vec("post_clk_div_lo", clk_div, 1'b0);
        step();
        check_vec("post_clk_div_hi", clk_div, 1'b1);

        // All three requesting: rotate every second frame.
        run_to(31);
        check_vec("rr_a_q", q, 16'hAAAA);
        step();
        check_vec("rr_b_q", q, 16'hBBBB);
        check_vec("rr_b_ack", ack, 3'b010);
        check_vec("rr_b_owner", owner, 2'd1);
        run_to(63);
        check_vec("rr_b_hold", q, 16'hBBBB);
        step();
        check_vec("rr_c_q", q, 16'hCCCC);
        check_vec("rr_c_ack", ack, 3'b100);
        check_vec("rr_c_owner", owner, 2'd2);
        run_to(95);
        check_vec("rr_c_hold", q, 16'hCCCC);
        step();
        check_vec("rr_a2_q", q, 16'hAAAA);
        check_vec("rr_a2_ack", ack, 3'b001);
        check_vec("rr_a2_owner", owner, 2'd0);

        // Sole requester is re-acked; data sampled only at the load edge.
        req = 3'b001; data0 = 16'h1111;
        run_to(127);
        check_vec("sole_hold_q", q, 16'hAAAA);
        check_vec("sole_hold_ack", ack, 3'b000);
        step();
        check_vec("sole_q", q, 16'h1111);
        check_vec("sole_ack", ack, 3'b001);
        check_vec("sole_owner", owner, 2'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
